// File: rtl/fetch_queue.sv
// In-order IF->ID instruction queue: pairs fetch metadata with in-order imem
// responses, hands completed entries to ID, and sheds in-flight fetches on flush.
package fetch_pkg;
    typedef struct packed {
        logic [31:0] pc_s;
        logic [31:0] pc_next_s;
        logic [63:0] order_s;
        logic        valid_s;
    } if_id_stage_reg_t;
endpackage

module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  if_id_stage_reg_t if_id_reg,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_resp,
    input  logic             flush,
    output logic             fetch_stall,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc_next,
    output logic [63:0]      id_order,
    output logic [31:0]      id_inst
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] done;
    logic [31:0]      pc_q      [DEPTH];
    logic [31:0]      pc_next_q [DEPTH];
    logic [63:0]      order_q   [DEPTH];
    logic [31:0]      inst_q    [DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] resp;
    logic [CW-1:0] count;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] discard_cnt;

    logic [CW:0] in_flight;
    logic        issue;
    logic        enq;
    logic        resp_drop;
    logic        resp_take;
    logic        resp_any;
    logic        deq;
    logic [CW-1:0] discard_next;

    // Stall counts queued entries plus orphaned responses still owed by imem.
    assign in_flight   = {1'b0, count} + {1'b0, discard_cnt};
    assign fetch_stall = in_flight >= (CW+1)'(DEPTH);

    assign issue     = if_id_reg.valid_s && !fetch_stall;
    assign enq       = issue && !flush;
    assign resp_drop = imem_resp && (discard_cnt != '0);
    assign resp_take = imem_resp && (discard_cnt == '0) && (wait_cnt != '0);
    assign resp_any  = resp_drop || resp_take;

    assign id_valid   = busy[head] && done[head];
    assign deq        = id_valid && id_ready;
    assign id_pc      = pc_q[head];
    assign id_pc_next = pc_next_q[head];
    assign id_order   = order_q[head];
    assign id_inst    = inst_q[head];

    always_comb begin
        discard_next = discard_cnt;
        if (flush) begin
            discard_next = discard_cnt + wait_cnt + CW'(issue) - CW'(resp_any);
        end else if (resp_drop) begin
            discard_next = discard_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            done        <= '0;
            head        <= '0;
            tail        <= '0;
            resp        <= '0;
            count       <= '0;
            wait_cnt    <= '0;
            discard_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]      <= '0;
                pc_next_q[i] <= '0;
                order_q[i]   <= '0;
                inst_q[i]    <= '0;
            end
        end else if (flush) begin
            busy        <= '0;
            done        <= '0;
            head        <= '0;
            tail        <= '0;
            resp        <= '0;
            count       <= '0;
            wait_cnt    <= '0;
            discard_cnt <= discard_next;
        end else begin
            discard_cnt <= discard_next;
            count       <= count + CW'(enq) - CW'(deq);
            wait_cnt    <= wait_cnt + CW'(enq) - CW'(resp_take);
            if (enq) begin
                busy[tail]      <= 1'b1;
                done[tail]      <= 1'b0;
                pc_q[tail]      <= if_id_reg.pc_s;
                pc_next_q[tail] <= if_id_reg.pc_next_s;
                order_q[tail]   <= if_id_reg.order_s;
                tail            <= tail + AW'(1);
            end
            if (resp_take) begin
                done[resp]   <= 1'b1;
                inst_q[resp] <= imem_rdata;
                resp         <= resp + AW'(1);
            end
            // Enqueue cannot hit the head slot while a dequeue is pending there:
            // a full queue stalls IF.
            if (deq) begin
                busy[head] <= 1'b0;
                done[head] <= 1'b0;
                head       <= head + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stream, full, flush and reset scenarios
// with hand-computed expectations.
module tb_fetch_queue;
    import fetch_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    if_id_stage_reg_t if_id_reg;
    logic [31:0]      imem_rdata;
    logic             imem_resp;
    logic             flush;
    logic             fetch_stall;
    logic             id_valid;
    logic             id_ready;
    logic [31:0]      id_pc;
    logic [31:0]      id_pc_next;
    logic [63:0]      id_order;
    logic [31:0]      id_inst;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_id_reg  (if_id_reg),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .flush      (flush),
        .fetch_stall(fetch_stall),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_pc      (id_pc),
        .id_pc_next (id_pc_next),
        .id_order   (id_order),
        .id_inst    (id_inst)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_id_reg  = '0;
        imem_resp  = 1'b0;
        imem_rdata = '0;
        flush      = 1'b0;
        id_ready   = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [63:0] ord);
        if_id_reg.valid_s   = 1'b1;
        if_id_reg.pc_s      = pc;
        if_id_reg.pc_next_s = pc + 32'd4;
        if_id_reg.order_s   = ord;
    endtask

    task automatic respond(input logic [31:0] data);
        imem_resp  = 1'b1;
        imem_rdata = data;
    endtask

    localparam logic [31:0] B = 32'h1eceb000;

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", id_valid, 0);
        chk("rst_stall", fetch_stall, 0);
        chk("rst_pc", id_pc, 0);
        chk("rst_inst", id_inst, 0);

        // stream
        idle(); fetch(B, 0); step();
        chk("s_lat", id_valid, 0);
        idle(); fetch(B + 4, 1); respond(32'hA0); id_ready = 1; step();
        chk("s0_valid", id_valid, 1);
        chk("s0_pc", id_pc, B);
        chk("s0_ord", id_order, 0);
        chk("s0_inst", id_inst, 32'hA0);
        chk("s0_pcn", id_pc_next, B + 4);
        idle(); fetch(B + 8, 2); respond(32'hA1); id_ready = 1; step();
        chk("s1_pc", id_pc, B + 4);
        chk("s1_ord", id_order, 1);
        chk("s1_inst", id_inst, 32'hA1);
        idle(); respond(32'hA2); id_ready = 1; step();
        chk("s2_pc", id_pc, B + 8);
        chk("s2_ord", id_order, 2);
        idle(); id_ready = 1; step();
        chk("s_empty", id_valid, 0);

        // full
        idle(); fetch(32'h100, 3); step();
        idle(); fetch(32'h104, 4); respond(32'hB0); step();
        idle(); fetch(32'h108, 5); respond(32'hB1); step();
        chk("f_nostall", fetch_stall, 0);
        idle(); fetch(32'h10c, 6); respond(32'hB2); step();
        chk("f_stall", fetch_stall, 1);
        idle(); fetch(32'h110, 7); respond(32'hB3); step();
        chk("f_stall2", fetch_stall, 1);
        chk("f_head", id_pc, 32'h100);
        idle(); id_ready = 1; step();
        chk("f_unstall", fetch_stall, 0);
        chk("f_adv", id_pc, 32'h104);
        idle(); id_ready = 1; step();
        chk("f_pc2", id_pc, 32'h108);
        idle(); id_ready = 1; step();
        chk("f_pc3", id_pc, 32'h10c);
        chk("f_inst3", id_inst, 32'hB3);
        idle(); id_ready = 1; step();
        chk("f_no5th", id_valid, 0);

        // flush with 3 in flight plus a flush-cycle issue
        idle(); fetch(32'h200, 8); step();
        idle(); fetch(32'h204, 9); step();
        idle(); fetch(32'h208, 10); step();
        idle(); fetch(32'h20c, 11); flush = 1; id_ready = 1; step();
        chk("fl_disc", dut.discard_cnt, 4);
        chk("fl_valid", id_valid, 0);
        chk("fl_stall", fetch_stall, 1);
        for (int i = 0; i < 4; i++) begin
            idle(); respond(32'hDEAD0000 + i); step();
        end
        chk("fl_drain", dut.discard_cnt, 0);
        chk("fl_unstall", fetch_stall, 0);
        chk("fl_empty", id_valid, 0);
        idle(); fetch(32'h300, 8); step();
        idle(); respond(32'hC0); step();
        chk("fl_pair_v", id_valid, 1);
        chk("fl_pair_pc", id_pc, 32'h300);
        chk("fl_pair_i", id_inst, 32'hC0);
        idle(); id_ready = 1; step();

        // flush coincident with response, 2 waiting
        idle(); fetch(32'h400, 9); step();
        idle(); fetch(32'h404, 10); step();
        idle(); flush = 1; respond(32'hEE); step();
        chk("fr_disc", dut.discard_cnt, 1);
        chk("fr_valid", id_valid, 0);
        idle(); respond(32'hEF); step();
        chk("fr_drop", id_valid, 0);
        chk("fr_disc0", dut.discard_cnt, 0);
        idle(); fetch(32'h500, 9); step();
        idle(); respond(32'hC1); step();
        chk("fr_pair", id_inst, 32'hC1);
        chk("fr_pc", id_pc, 32'h500);
        idle(); id_ready = 1; step();

        // flush while stalled: issue not counted
        for (int i = 0; i < 4; i++) begin
            idle(); fetch(32'h600 + 4 * i, 10 + i); step();
        end
        chk("fs_stall", fetch_stall, 1);
        idle(); fetch(32'h610, 14); flush = 1; respond(32'hEE); step();
        chk("fs_disc", dut.discard_cnt, 3);
        for (int i = 0; i < 3; i++) begin
            idle(); respond(32'hEE); step();
        end
        chk("fs_drain", dut.discard_cnt, 0);

        // simultaneous enq+resp+deq at count 2
        idle(); fetch(32'h700, 20); step();
        idle(); fetch(32'h704, 21); respond(32'hD0); step();
        chk("sim_cnt0", dut.count, 2);
        idle(); fetch(32'h708, 22); respond(32'hD1); id_ready = 1; step();
        chk("sim_cnt", dut.count, 2);
        chk("sim_pc", id_pc, 32'h704);
        chk("sim_ord", id_order, 21);
        idle(); respond(32'hD2); id_ready = 1; step();
        chk("sim_ord2", id_order, 22);
        chk("sim_inst2", id_inst, 32'hD2);
        idle(); id_ready = 1; step();
        chk("sim_empty", id_valid, 0);

        // reset mid-stream with DONE entries
        idle(); fetch(32'h800, 30); step();
        idle(); fetch(32'h804, 31); respond(32'hF0); step();
        idle(); respond(32'hF1); step();
        chk("r_pre", id_valid, 1);
        idle(); rst = 1; flush = 1; step();
        rst = 0;
        chk("r_valid", id_valid, 0);
        chk("r_stall", fetch_stall, 0);
        chk("r_pc", id_pc, 0);
        chk("r_order", id_order, 0);
        chk("r_inst", id_inst, 0);
        idle(); fetch(32'h900, 0); step();
        chk("r_tail", dut.tail, 1);
        idle(); respond(32'hF9); step();
        chk("r_slot0", dut.head, 0);
        chk("r_pc2", id_pc, 32'h900);
        chk("r_inst2", id_inst, 32'hF9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
